// File: rtl/lvds_pkg.sv
// Shared LVDS definitions for the auto-align transmitter/receiver pair.
package lvds_pkg;

  localparam int unsigned LVDS_DATA_W = 8;
  localparam logic [LVDS_DATA_W-1:0] TRAIN_PAT_DEF = 8'hF0;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } align_state_e;

endpackage

// File: rtl/lvds_word_align_shifter.sv
// Two-word sliding window over the deserializer output with a barrel-shift
// tap selecting the candidate word at the current bit offset.
module lvds_word_align_shifter
  import lvds_pkg::*;
#(
  parameter int unsigned DATA_W = LVDS_DATA_W
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         rx_data,
  input  logic                      rx_valid,
  input  logic [$clog2(DATA_W)-1:0] offset,
  output logic [DATA_W-1:0]         aligned
);

  logic [2*DATA_W-1:0] win_q;
  logic [2*DATA_W-1:0] shifted;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      win_q <= '0;
    end else if (rx_valid) begin
      win_q <= {rx_data, win_q[2*DATA_W-1:DATA_W]};
    end
  end

  assign shifted = win_q >> offset;
  assign aligned = shifted[DATA_W-1:0];

endmodule

// File: rtl/data_receive_auto_align.sv
// Receive-side word aligner: searches for the training pattern, verifies it,
// then delivers aligned words. Optional sequence checker: RX_SEQ_CHECK_EN.
module data_receive_auto_align
  import lvds_pkg::*;
#(
  parameter int unsigned          DATA_W    = LVDS_DATA_W,
  parameter logic [DATA_W-1:0]    TRAIN_PAT = TRAIN_PAT_DEF,
  parameter int unsigned          LOCK_CNT  = 16,
  parameter int unsigned          LOSS_CNT  = 4,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              relock,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              is_train,
  output logic              align_lock,
  output logic [2:0]        align_offset,
  output logic              seq_err,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned CW = $clog2(LOCK_CNT + 1);

  align_state_e      state_q;
  logic [2:0]        offset_q;
  logic [CW-1:0]     match_cnt_q;
  logic              step_q;
  logic [DATA_W-1:0] aligned;
  logic              is_pat;
  logic              seq_loss;

  lvds_word_align_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .offset   (offset_q),
    .aligned  (aligned)
  );

  assign is_pat       = (aligned == TRAIN_PAT);
  assign align_offset = offset_q;

  // step_q marks that the window took a new word on the previous edge.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      offset_q    <= '0;
      match_cnt_q <= '0;
      step_q      <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      is_train    <= 1'b0;
      align_lock  <= 1'b0;
    end else begin
      step_q     <= rx_valid;
      data_valid <= 1'b0;
      if (relock) begin
        state_q     <= SEARCH;
        match_cnt_q <= '0;
        align_lock  <= 1'b0;
      end else if (step_q) begin
        unique case (state_q)
          SEARCH: begin
            if (is_pat) begin
              state_q     <= VERIFY;
              match_cnt_q <= CW'(1);
            end else begin
              offset_q <= offset_q + 3'd1;
            end
          end
          VERIFY: begin
            if (is_pat) begin
              match_cnt_q <= match_cnt_q + CW'(1);
              if (match_cnt_q == CW'(LOCK_CNT - 1)) begin
                state_q    <= LOCKED;
                align_lock <= 1'b1;
              end
            end else begin
              state_q     <= SEARCH;
              offset_q    <= offset_q + 3'd1;
              match_cnt_q <= '0;
            end
          end
          LOCKED: begin
            data_out   <= aligned;
            data_valid <= 1'b1;
            is_train   <= is_pat;
            if (seq_loss) begin
              state_q     <= SEARCH;
              match_cnt_q <= '0;
              align_lock  <= 1'b0;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

`ifdef RX_SEQ_CHECK_EN
  localparam int unsigned LW = $clog2(LOSS_CNT + 1);

  logic              seeded_q;
  logic [DATA_W-1:0] exp_word_q;
  logic [LW-1:0]     bad_run_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic              seq_err_q;
  logic              seq_bad;

  assign seq_bad  = step_q && !relock && (state_q == LOCKED) && !is_pat && seeded_q &&
                    (aligned != exp_word_q);
  assign seq_loss = seq_bad && (bad_run_q == LW'(LOSS_CNT - 1));

  // Training words and any exit from LOCKED un-seed the expectation.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      seeded_q   <= 1'b0;
      exp_word_q <= '0;
      bad_run_q  <= '0;
      err_cnt_q  <= '0;
      seq_err_q  <= 1'b0;
    end else begin
      seq_err_q <= seq_bad;
      if (state_q != LOCKED || relock) begin
        seeded_q  <= 1'b0;
        bad_run_q <= '0;
      end else if (step_q) begin
        if (is_pat) begin
          seeded_q  <= 1'b0;
          bad_run_q <= '0;
        end else if (!seeded_q) begin
          seeded_q   <= 1'b1;
          exp_word_q <= aligned + DATA_W'(1);
        end else if (aligned == exp_word_q) begin
          exp_word_q <= aligned + DATA_W'(1);
          bad_run_q  <= '0;
        end else begin
          exp_word_q <= aligned + DATA_W'(1);
          bad_run_q  <= bad_run_q + LW'(1);
          if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign seq_err = seq_err_q;
  assign err_cnt = err_cnt_q;
`else
  assign seq_loss = 1'b0;
  assign seq_err  = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule

// File: doc/data_receive_auto_align.md
Name: data_receive_auto_align

Overview:
- Receive-side counterpart of the LVDS auto-align transmitter.
- Takes the parallel words from the LVDS deserializer and finds the word boundary by sliding a barrel-shift window until the transmitter's training pattern repeats.
- Once locked, it delivers byte-aligned payload words to the downstream logic of the LVDS test design.
- Sits between the deserializer parallel output and the receive data consumer, all in the deserializer parallel-clock domain.

Parameters:
- DATA_W, 8, deserialized word width.
- TRAIN_PAT, 8'hF0, training word sent by the transmitter; all 8 rotations are distinct.
- LOCK_CNT, 16, consecutive matching training words needed to declare lock.
- LOSS_CNT, 4, consecutive sequence errors that drop lock (used only with the optional feature).
- CNT_W, 16, width of the error counter.

Ports:
- sys_clk  input  1  deserializer parallel clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  DATA_W  raw, unaligned deserializer word.
- rx_valid  input  1  rx_data qualifier; no state advances when low.
- relock  input  1  1-cycle pulse that forces re-search from any state.
- data_out  output  DATA_W  aligned word.
- data_valid  output  1  high for each aligned word delivered while LOCKED.
- is_train  output  1  qualifies data_out as equal to TRAIN_PAT.
- align_lock  output  1  high in LOCKED.
- align_offset  output  3  current window bit offset.
- seq_err  output  1  1-cycle sequence-error pulse (optional feature only; otherwise tied 0).
- err_cnt  output  CNT_W  saturating sequence-error count (optional feature only; otherwise tied 0).

Behaviour:
- Reset values (rst high at a clock edge):
  - state = SEARCH; window = 0; offset = 0; match count = 0.
  - All outputs 0.
  - Reset mid-operation returns to exactly this state on the next edge.
- Window: on each rx_valid cycle, win[15:8] <= rx_data and win[7:0] <= previous win[15:8]. aligned = win[offset +: 8], combinational.
- Compare/advance step: evaluated only in cycles where the window was updated on the previous edge (track with a registered valid flag).
- States:
  - SEARCH:
    - aligned == TRAIN_PAT -> VERIFY, match count = 1.
    - Otherwise offset <= offset+1 (wraps 7 -> 0).
  - VERIFY:
    - Match -> count+1; when count reaches LOCK_CNT -> LOCKED.
    - Mismatch -> SEARCH, offset+1, count = 0.
  - LOCKED:
    - align_lock = 1; offset frozen.
    - Every compare step, data_out <= aligned and data_valid <= 1; otherwise data_valid = 0.
    - is_train <= (aligned == TRAIN_PAT).
- relock pulse: in any state -> SEARCH next edge; offset unchanged; count = 0; align_lock cleared the same edge. relock wins over a simultaneous lock transition.
- Latency: rx_data to data_out is 2 sys_clk cycles (window register, then output register).
- align_offset reflects the offset register directly.
- Without the optional feature, LOCKED is left only via relock or rst.

Optional Feature:
- Macro: RX_SEQ_CHECK_EN.
- When defined:
  - In LOCKED, non-training words must form an incrementing modulo-256 sequence. The first payload word after lock or a training word seeds the expectation.
  - Each mismatch pulses seq_err for 1 cycle, increments err_cnt (saturates at all-ones), and re-seeds the expectation to received+1.
  - LOSS_CNT consecutive mismatches -> SEARCH, align_lock drops.
  - err_cnt clears only on rst.
- When undefined: no checker logic; seq_err and err_cnt are constant 0.

Decomposition:
- Shared package lvds_pkg:
  - state enum (SEARCH, VERIFY, LOCKED);
  - TRAIN_PAT default constant;
  - DATA_W constant (shared with the transmitter).
- One sub-module is natural: lvds_word_align_shifter, holding the window register and the barrel-shift mux (inputs rx_data, rx_valid, offset; output aligned).

Test Plan:
- TRAIN_PAT stream rotated by 3 bits, rx_valid always 1 -> align_offset settles to 5, align_lock high after 16 matches, data_out = 8'hF0, is_train = 1.
- After lock, payload 8'h00..8'hFF at the same skew -> data_out shows 00,01,... with 2-cycle latency; seq_err never pulses.
- rx_valid toggling 1010 during training -> lock takes 16 valid words; no offset advance on invalid cycles.
- Single corrupted word (8'h07) during VERIFY at count 10 -> back to SEARCH, offset+1, then relock.
- relock pulse while LOCKED -> align_lock 0 next edge; relocks at the same offset after 16 training words. rst mid-VERIFY -> all outputs 0.
- With RX_SEQ_CHECK_EN: payload 00,01,05,06 -> one seq_err pulse, err_cnt = 1, lock held. Four consecutive bad words -> lock lost, state SEARCH.
